// File: rtl/i_cache_axi_rd.sv
// Instruction-cache refill bridge: turns a level-held miss into one single-beat AXI4 read.
// Optional `YSYX22040228_ICACHE_AXI_ERR_EN adds cache_rd_err and returns a NOP on error.
module i_cache_axi_rd #(
  parameter int              ID_W       = 4,
  parameter logic [ID_W-1:0] AXI_ID     = 4'b0001,
  parameter int              AXI_DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_read_ena,
  input  logic [63:0]           cache_addr,
  output logic [31:0]           cache_or_data,
  output logic                  cache_in_ok,
`ifdef YSYX22040228_ICACHE_AXI_ERR_EN
  output logic                  cache_rd_err,
`endif
  output logic                  axi_ar_valid,
  input  logic                  axi_ar_ready,
  output logic [63:0]           axi_ar_addr,
  output logic [ID_W-1:0]       axi_ar_id,
  output logic [7:0]            axi_ar_len,
  output logic [2:0]            axi_ar_size,
  output logic [1:0]            axi_ar_burst,
  input  logic                  axi_r_valid,
  output logic                  axi_r_ready,
  input  logic [AXI_DATA_W-1:0] axi_r_data,
  input  logic [1:0]            axi_r_resp,
  input  logic                  axi_r_last,
  input  logic [ID_W-1:0]       axi_r_id
);

  localparam logic [3:0] S_IDLE = 4'b0001;
  localparam logic [3:0] S_AR   = 4'b0010;
  localparam logic [3:0] S_R    = 4'b0100;
  localparam logic [3:0] S_RESP = 4'b1000;

  logic [3:0]  state_q, state_d;
  logic [63:0] addr_q;
  logic        keep_q;
  logic        captured_q;
  logic [31:0] data_q;
  logic        in_idle, in_ar, in_r, in_resp;
  logic        beat_match;
  logic        unused_bits;

  assign in_idle    = state_q[0];
  assign in_ar      = state_q[1];
  assign in_r       = state_q[2];
  assign in_resp    = state_q[3];
  assign beat_match = in_r && axi_r_valid && (axi_r_id == AXI_ID);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cache_read_ena) state_d = S_AR;
      S_AR:    if (axi_ar_ready) state_d = S_R;
      S_R:     if (beat_match && axi_r_last) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control: state, address latch, keep (request still wanted) and capture flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      keep_q     <= 1'b0;
      captured_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (in_idle && cache_read_ena) begin
        addr_q <= {cache_addr[63:2], 2'b00};
        keep_q <= 1'b1;
      end
      // A dropped request still drains on AXI; only the completion pulse is suppressed.
      if ((in_ar || in_r) && !cache_read_ena) keep_q <= 1'b0;
      if (in_idle) captured_q <= 1'b0;
      else if (beat_match) captured_q <= 1'b1;
    end
  end

  // Data: first matching beat only, lane picked by address bit 2
  always_ff @(posedge clk) begin
    if (beat_match && !captured_q)
      data_q <= addr_q[2] ? axi_r_data[63:32] : axi_r_data[31:0];
  end

  assign axi_ar_valid = in_ar;
  assign axi_ar_addr  = addr_q;
  assign axi_ar_id    = AXI_ID;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_size  = 3'b010;
  assign axi_ar_burst = 2'b01;
  assign axi_r_ready  = in_r;
  assign cache_in_ok  = in_resp && keep_q;

`ifdef YSYX22040228_ICACHE_AXI_ERR_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (in_idle) err_q <= 1'b0;
    else if (beat_match && axi_r_resp[1]) err_q <= 1'b1;
  end

  assign cache_rd_err  = cache_in_ok && err_q;
  assign cache_or_data = !cache_in_ok ? 32'h0 : (err_q ? 32'h0000_0013 : data_q);
  assign unused_bits   = ^{cache_addr[1:0], axi_r_resp[0]};
`else
  assign cache_or_data = cache_in_ok ? data_q : 32'h0;
  assign unused_bits   = ^{cache_addr[1:0], axi_r_resp};
`endif

endmodule

// File: doc/i_cache_axi_rd.md
Name: i_cache_axi_rd

Overview:
- Refill-side read bridge between the instruction cache miss port and the AXI4 read channels (AR/R).
- Accepts a level-held miss request and issues one single-beat AXI4 read.
- Returns the 32-bit instruction word with a one-cycle completion pulse.
- Sits directly downstream of the i-cache and upstream of the AXI interconnect/arbiter.

Parameters:
AXI_ID, 4'b0001, ARID driven on every request; R beats with a different RID are discarded
ID_W, 4, width of ARID/RID
AXI_DATA_W, 64, R data bus width (fixed at 64; lane select uses addr[2])

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
cache_read_ena  input  1  miss request level; held high by the cache until cache_in_ok is seen
cache_addr  input  64  instruction byte address of the miss
cache_or_data  output  32  refilled instruction word, valid only while cache_in_ok=1
cache_in_ok  output  1  one-cycle completion pulse
axi_ar_valid  output  1  AR valid
axi_ar_ready  input  1  AR ready
axi_ar_addr  output  64  {cache_addr[63:2],2'b00}, latched
axi_ar_id  output  ID_W  = AXI_ID
axi_ar_len  output  8  constant 8'd0
axi_ar_size  output  3  constant 3'b010 (4 bytes)
axi_ar_burst  output  2  constant 2'b01 (INCR)
axi_r_valid  input  1  R valid
axi_r_ready  output  1  R ready
axi_r_data  input  64  R data
axi_r_resp  input  2  R response
axi_r_last  input  1  R last
axi_r_id  input  ID_W  R id

Behaviour:
- Reset: clock and reset are one clock `clk` and reset `rst`, asynchronous, active-low. While rst=0: state=IDLE, axi_ar_valid=0, axi_r_ready=0, cache_in_ok=0, cache_or_data=0, addr latch=0, keep flag=0.
- One-hot FSM: IDLE, AR, R, RESP. All outputs are registered or decoded from state only.
- IDLE: on cache_read_ena=1:
  - latch {cache_addr[63:2],2'b00};
  - set keep=1;
  - go to AR next cycle.
- AR: axi_ar_valid=1 with the latched address.
  - Valid and address stay stable until axi_ar_ready=1, per the AXI rule.
  - On handshake, go to R.
  - AR is never withdrawn, even if cache_read_ena drops.
- R: axi_r_ready=1.
  - A beat with axi_r_valid=1 and axi_r_id!=AXI_ID is accepted and ignored.
  - The first matching beat captures axi_r_data[63:32] if addr[2]=1, otherwise axi_r_data[31:0].
  - Later matching beats before r_last are consumed and dropped.
  - The matching beat with r_last=1 moves to RESP.
- RESP: one cycle. cache_in_ok=keep; cache_or_data=captured word (0 when cache_in_ok=0). Always return to IDLE.
- Latency: with ar_ready and r_valid both immediate, request seen in cycle 0 gives AR valid in cycle 1, R accepted in cycle 2, cache_in_ok in cycle 3.
- Abort: if cache_read_ena=0 in any cycle while in AR or R, clear keep. The transaction still drains on AXI and RESP produces no pulse.
- Re-trigger guard: the cache drops cache_read_ena combinationally on cache_in_ok. IDLE re-samples only from the cycle after RESP, so a stale level cannot issue a duplicate AR.
- cache_addr changes while busy are ignored; only the latched address is used.
- axi_r_resp is ignored unless the optional feature is compiled in.
- Reset mid-transaction returns to IDLE immediately. Outstanding AXI beats after reset are the interconnect's responsibility.

Optional Feature:
- Macro: YSYX22040228_ICACHE_AXI_ERR_EN.
- When defined:
  - adds output cache_rd_err (1 bit), pulsed together with cache_in_ok when any matching beat had axi_r_resp[1]=1 (SLVERR/DECERR);
  - on error, cache_or_data is forced to 32'h0000_0013 (NOP), so a cache fill does not inject garbage;
  - the error flag clears in IDLE.
- When undefined: no port, resp is ignored, raw data is returned.

Test Plan:
- Aligned low word: cache_read_ena=1, cache_addr=64'h8000_0000; ar_ready=1; R beat data=64'hAAAA_BBBB_0010_0513, last=1, resp=0 -> axi_ar_addr=64'h8000_0000, len=0, size=2; cache_in_ok pulses 1 cycle in cycle 3 with cache_or_data=32'h0010_0513.
- High word plus backpressure: cache_addr=64'h8000_0004, ar_ready low for 3 cycles -> ar_valid and addr stable all 3 cycles; on data 64'h1234_5678_0000_0000 -> cache_or_data=32'h1234_5678.
- Foreign RID: an R beat with id=4'h2 arrives first, then a matching beat with data low=32'h0000_0073 -> first beat discarded, returned word is 32'h0000_0073, exactly one pulse.
- Abort: cache_read_ena dropped while in R -> R beat consumed, r_ready=1 on it, cache_in_ok never asserts, FSM back in IDLE; next request proceeds normally.
- Back-to-back: cache_read_ena deasserted in the cache_in_ok cycle and reasserted 1 cycle later with a new address -> exactly one AR per request, no duplicate AR.
- ERR_EN build: resp=2'b10 -> cache_rd_err=1 with cache_in_ok, cache_or_data=32'h0000_0013. Without the macro the same stimulus returns raw data. Asserting rst=0 mid-AR clears ar_valid asynchronously.
